// File: rtl/reg_seq_ctrl.sv
// Power regulator sequencer: VPRE soft start, then six regulators enabled slot by slot, reverse order on stop.
// Latency: one main_clk20m cycle from any input to the registered enables/status; each slot lasts SLOT_CYC cycles.
// Backpressure: none; start/stop/fault_clr are single-cycle pulses, ignored in states that have no use for them.
//
// Ports: main_clk20m + por (synchronous, active-high); start/stop/fault_clr requests; slot_* per-regulator slot
//   number (7 = never used); ssready, *_sta, flt_in status inputs; en* regulator enables; seq_done, seq_fault,
//   seq_state, seq_slot sequencer status.
// Build option: define REG_SEQ_SLOT_SKIP_EN to make a slot with no regulator assigned last a single cycle.
module reg_seq_ctrl #(
  parameter int UDLY     = 1,
  parameter int SLOT_CYC = 20000,
  parameter int PRE_TMO  = 100000
) (
  input  logic       main_clk20m,
  input  logic       por,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_clr,
  input  logic [2:0] slot_boost,
  input  logic [2:0] slot_buck1,
  input  logic [2:0] slot_buck2,
  input  logic [2:0] slot_buck3,
  input  logic [2:0] slot_ldo1,
  input  logic [2:0] slot_ldo2,
  input  logic       ssready,
  input  logic       boost_sta,
  input  logic       buck1_sta,
  input  logic       buck2_sta,
  input  logic       buck3_sta,
  input  logic       ldo1_sta,
  input  logic       ldo2_sta,
  input  logic       flt_in,
  output logic       enpre,
  output logic       enboost,
  output logic       enbuck1,
  output logic       enbuck2,
  output logic       enbuck3,
  output logic       enldo1,
  output logic       enldo2,
  output logic       seq_done,
  output logic       seq_fault,
  output logic [2:0] seq_state,
  output logic [2:0] seq_slot
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE_ON  = 3'd1,
    S_SLOT_UP = 3'd2,
    S_ON      = 3'd3,
    S_SLOT_DN = 3'd4,
    S_PRE_OFF = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // UDLY only ever delayed behavioural-model updates; these registers update
  // with zero delay, so it is folded in with no effect on the value.
  localparam logic [19:0] SLOT_LAST = 20'(SLOT_CYC - 1);
  localparam logic [19:0] PRE_LAST  = 20'(PRE_TMO - 1 + 0 * UDLY);

  // Regulator index order everywhere: 0 boost, 1 buck1, 2 buck2, 3 buck3, 4 ldo1, 5 ldo2.
  logic [5:0][2:0] slot_cfg;
  logic [5:0]      sta;

  assign slot_cfg = {slot_ldo2, slot_ldo1, slot_buck3, slot_buck2, slot_buck1, slot_boost};
  assign sta      = {ldo2_sta, ldo1_sta, buck3_sta, buck2_sta, buck1_sta, boost_sta};

  function automatic logic [5:0] in_slot(input logic [5:0][2:0] cfg, input logic [2:0] k);
    logic [5:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) m[i] = (cfg[i] == k);
    return m;
  endfunction

  // Slot 7 is excluded explicitly so an unused regulator is never checked.
  function automatic logic [5:0] up_to_slot(input logic [5:0][2:0] cfg, input logic [2:0] k);
    logic [5:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) m[i] = (cfg[i] <= k) && (cfg[i] != 3'd7);
    return m;
  endfunction

  state_t      state_q;
  logic [2:0]  slot_q;
  logic [19:0] timer_q;
  logic [5:0]  en_q;
  logic        enpre_q;
  logic        done_q;
  logic        fault_q;

  logic [5:0]  on_cur, on_next, on_prev, on_zero, on_six, chk_mask;
  logic        slot_skip, slot_end, chk_ok, fault_req;

  // on_next/on_prev wrap to 7 at the ends but are only used when slot_q is 0..5 / 1..6.
  assign on_cur   = in_slot(slot_cfg, slot_q);
  assign on_next  = in_slot(slot_cfg, slot_q + 3'd1);
  assign on_prev  = in_slot(slot_cfg, slot_q - 3'd1);
  assign on_zero  = in_slot(slot_cfg, 3'd0);
  assign on_six   = in_slot(slot_cfg, 3'd6);
  assign chk_mask = up_to_slot(slot_cfg, slot_q);

`ifdef REG_SEQ_SLOT_SKIP_EN
  assign slot_skip = ~|on_cur;
`else
  assign slot_skip = 1'b0;
`endif

  // A skipped slot ends immediately and performs no status check.
  assign slot_end = slot_skip || (timer_q == SLOT_LAST);
  assign chk_ok   = slot_skip || (&(sta | ~chk_mask));

  // Everything that sends the sequencer to FAULT; evaluated ahead of stop/start/timer.
  always_comb begin
    fault_req = 1'b0;
    case (state_q)
      S_PRE_ON:             fault_req = flt_in || (!ssready && timer_q == PRE_LAST);
      S_SLOT_UP:            fault_req = flt_in || !ssready || (slot_end && !chk_ok);
      S_ON:                 fault_req = flt_in || !ssready;
      S_SLOT_DN, S_PRE_OFF: fault_req = flt_in;
      default:              fault_req = 1'b0;
    endcase
  end

  always_ff @(posedge main_clk20m) begin
    if (por) begin
      state_q <= S_IDLE;
      slot_q  <= 3'd0;
      timer_q <= '0;
      en_q    <= '0;
      enpre_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (fault_req) begin
      state_q <= S_FAULT;
      timer_q <= '0;
      en_q    <= '0;
      enpre_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_PRE_ON;
            enpre_q <= 1'b1;
            slot_q  <= 3'd0;
            timer_q <= '0;
          end
        end
        S_PRE_ON: begin
          if (ssready) begin
            state_q <= S_SLOT_UP;
            slot_q  <= 3'd0;
            timer_q <= '0;
            en_q    <= en_q | on_zero;
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        S_SLOT_UP: begin
          if (stop) begin
            // Abort: unwind from the slot currently being brought up.
            state_q <= S_SLOT_DN;
            timer_q <= '0;
            en_q    <= en_q & ~on_cur;
          end else if (slot_end) begin
            timer_q <= '0;
            if (slot_q == 3'd6) begin
              state_q <= S_ON;
              done_q  <= 1'b1;
            end else begin
              slot_q <= slot_q + 3'd1;
              en_q   <= en_q | on_next;
            end
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        S_ON: begin
          if (stop) begin
            state_q <= S_SLOT_DN;
            slot_q  <= 3'd6;
            timer_q <= '0;
            done_q  <= 1'b0;
            en_q    <= en_q & ~on_six;
          end
        end
        S_SLOT_DN: begin
          if (slot_end) begin
            timer_q <= '0;
            if (slot_q == 3'd0) begin
              state_q <= S_PRE_OFF;
              enpre_q <= 1'b0;
            end else begin
              slot_q <= slot_q - 3'd1;
              en_q   <= en_q & ~on_prev;
            end
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        S_PRE_OFF: begin
          if (timer_q == SLOT_LAST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        S_FAULT: begin
          if (fault_clr && !flt_in) begin
            state_q <= S_IDLE;
            slot_q  <= 3'd0;
            timer_q <= '0;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign enpre     = enpre_q;
  assign enboost   = en_q[0];
  assign enbuck1   = en_q[1];
  assign enbuck2   = en_q[2];
  assign enbuck3   = en_q[3];
  assign enldo1    = en_q[4];
  assign enldo2    = en_q[5];
  assign seq_done  = done_q;
  assign seq_fault = fault_q;
  assign seq_state = state_q;
  assign seq_slot  = slot_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl with SLOT_CYC=8, PRE_TMO=16: vector table, directed corner sequences,
// and randomized up/down sequences checked against a timeline model.
// Works with or without REG_SEQ_SLOT_SKIP_EN defined.
module tb_reg_seq_ctrl;

  localparam int SLOT = 8;
  localparam int TMO  = 16;
`ifdef REG_SEQ_SLOT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic main_clk20m = 1'b0;
  logic por = 1'b1, start = 1'b0, stop = 1'b0, fault_clr = 1'b0, ssready = 1'b0, flt_in = 1'b0;
  logic [5:0][2:0] cfg = {6{3'd7}};
  logic [5:0] sta_kill = '0;
  logic boost_sta, buck1_sta, buck2_sta, buck3_sta, ldo1_sta, ldo2_sta;
  logic enpre, enboost, enbuck1, enbuck2, enbuck3, enldo1, enldo2, seq_done, seq_fault;
  logic [2:0] seq_state, seq_slot;
  logic [5:0] en_v;
  logic [14:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 main_clk20m = ~main_clk20m;

  reg_seq_ctrl #(.UDLY(1), .SLOT_CYC(SLOT), .PRE_TMO(TMO)) dut (
    .main_clk20m(main_clk20m), .por(por), .start(start), .stop(stop), .fault_clr(fault_clr),
    .slot_boost(cfg[0]), .slot_buck1(cfg[1]), .slot_buck2(cfg[2]),
    .slot_buck3(cfg[3]), .slot_ldo1(cfg[4]), .slot_ldo2(cfg[5]),
    .ssready(ssready), .boost_sta(boost_sta), .buck1_sta(buck1_sta), .buck2_sta(buck2_sta),
    .buck3_sta(buck3_sta), .ldo1_sta(ldo1_sta), .ldo2_sta(ldo2_sta), .flt_in(flt_in),
    .enpre(enpre), .enboost(enboost), .enbuck1(enbuck1), .enbuck2(enbuck2), .enbuck3(enbuck3),
    .enldo1(enldo1), .enldo2(enldo2), .seq_done(seq_done), .seq_fault(seq_fault),
    .seq_state(seq_state), .seq_slot(seq_slot)
  );

  // Regulator plant: status follows its enable unless forced low.
  assign en_v = {enldo2, enldo1, enbuck3, enbuck2, enbuck1, enboost};
  assign {ldo2_sta, ldo1_sta, buck3_sta, buck2_sta, buck1_sta, boost_sta} = en_v & ~sta_kill;
  assign obs = {seq_state, seq_slot, enpre, en_v, seq_done, seq_fault};

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge main_clk20m);
    #1;
  endtask

  task automatic do_reset();
    por = 1'b1; start = 1'b0; stop = 1'b0; fault_clr = 1'b0; flt_in = 1'b0; ssready = 1'b0;
    tick();
    tick();
    por = 1'b0;
  endtask

  // Table of single-cycle vectors: inputs {por,start,stop,fault_clr,ssready,flt_in},
  // expected state, slot and {enpre,seq_done,seq_fault}; all regulators unused.
  typedef struct packed {
    logic [5:0] in;
    logic [2:0] st;
    logic [2:0] sl;
    logic [2:0] fl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [5:0] in, input logic [2:0] st, input logic [2:0] sl, input logic [2:0] fl);
    vec_t v;
    v.in = in; v.st = st; v.sl = sl; v.fl = fl;
    tbl.push_back(v);
  endtask

  // One full sequence: start at cycle 0, ssready from cycle s_ss, a stop pulse at a chosen cycle.
  // Expected outputs come from slot start/end times computed by summing slot durations.
  task automatic run_trial(input logic [5:0][2:0] c_cfg, input int s_ss, input int ts_rel, input int id);
    int dur[7];
    int us[8];
    int dn[8];
    int u0, done_t, ts, kk, d0, pre_off, idle_t;
    bit used;
    logic [2:0] st, sl;
    logic [5:0] en_e;
    logic pre_e, done_e;
    cfg = c_cfg;
    sta_kill = '0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      used = 1'b0;
      for (int r = 0; r < 6; r++) if (int'(c_cfg[r]) == i) used = 1'b1;
      dur[i] = (SKIP && !used) ? 1 : SLOT;
    end
    u0 = ((s_ss > 1) ? s_ss : 1) + 1;
    us[0] = u0;
    for (int k = 1; k < 8; k++) us[k] = us[k-1] + dur[k-1];
    done_t = us[7];
    if (ts_rel < 0) ts = done_t - ts_rel;
    else ts = u0 + (ts_rel % (done_t + 6 - u0));
    kk = 0;
    for (int k = 0; k < 7; k++) if (us[k] <= ts) kk = k;
    d0 = ts + 1;
    for (int j = 0; j < 8; j++) dn[j] = 0;
    dn[kk] = d0;
    for (int j = kk - 1; j >= 0; j--) dn[j] = dn[j+1] + dur[j+1];
    pre_off = dn[0] + dur[0];
    idle_t  = pre_off + SLOT;
    for (int c = 0; c <= idle_t + 2; c++) begin
      start   = (c == 0);
      ssready = (c >= s_ss);
      stop    = (c == ts);
      @(negedge main_clk20m);
      st = 3'd0; sl = 3'd0; done_e = 1'b0;
      if (c == 0) st = 3'd0;
      else if (c < u0) st = 3'd1;
      else if (c < d0 && c < done_t) begin
        st = 3'd2;
        for (int k = 0; k < 7; k++) if (us[k] <= c) sl = 3'(k);
      end else if (c < d0) begin
        st = 3'd3; sl = 3'd6; done_e = 1'b1;
      end else if (c < pre_off) begin
        st = 3'd4;
        for (int j = kk; j >= 0; j--) if (dn[j] <= c) sl = 3'(j);
      end else if (c < idle_t) st = 3'd5;
      pre_e = (c >= 1) && (c < pre_off);
      for (int r = 0; r < 6; r++)
        en_e[r] = (c_cfg[r] != 3'd7) && (int'(c_cfg[r]) <= kk) &&
                  (c >= us[c_cfg[r]]) && (c < dn[c_cfg[r]]);
      check($sformatf("trial%0d_c%0d", id, c), obs, {st, sl, pre_e, en_e, done_e, 1'b0});
      tick();
    end
    stop = 1'b0;
    ssready = 1'b0;
  endtask

  initial begin
    // ---------------- table-driven vectors ----------------
    add(6'b100000, 3'd0, 3'd0, 3'b000);  // reset
    add(6'b001001, 3'd0, 3'd0, 3'b000);  // stop/fault ignored in IDLE
    add(6'b010001, 3'd1, 3'd0, 3'b100);  // start, fault still ignored in IDLE
    add(6'b010000, 3'd1, 3'd0, 3'b100);  // start outside IDLE ignored
    add(6'b000010, 3'd2, 3'd0, 3'b100);  // soft start done
    add(6'b000000, 3'd6, 3'd0, 3'b001);  // ssready lost in SLOT_UP
    add(6'b000101, 3'd6, 3'd0, 3'b001);  // clear ignored while fault present
    add(6'b010000, 3'd6, 3'd0, 3'b001);  // start ignored in FAULT
    add(6'b000100, 3'd0, 3'd0, 3'b000);  // clear accepted
    add(6'b010000, 3'd1, 3'd0, 3'b100);
    add(6'b000010, 3'd2, 3'd0, 3'b100);
    add(6'b011010, 3'd4, 3'd0, 3'b100);  // stop beats start in SLOT_UP
    add(6'b001011, 3'd6, 3'd0, 3'b001);  // fault beats stop in SLOT_DN
    add(6'b100000, 3'd0, 3'd0, 3'b000);  // reset out of FAULT
    add(6'b010000, 3'd1, 3'd0, 3'b100);
    add(6'b000010, 3'd2, 3'd0, 3'b100);
    add(6'b100010, 3'd0, 3'd0, 3'b000);  // reset mid-sequence
    cfg = {6{3'd7}};
    for (int i = 0; i < tbl.size(); i++) begin
      {por, start, stop, fault_clr, ssready, flt_in} = tbl[i].in;
      tick();
      check($sformatf("vec%0d", i), obs,
            {tbl[i].st, tbl[i].sl, tbl[i].fl[2], 6'b0, tbl[i].fl[1], tbl[i].fl[0]});
    end

    // ---------------- soft start timeout ----------------
    cfg = {6{3'd7}};
    do_reset();
    start = 1'b1; tick(); start = 1'b0;          // cycle 1
    repeat (15) tick();                           // cycle 16, last PRE_ON cycle
    check("pre_on_last", obs, {3'd1, 3'd0, 1'b1, 6'b0, 1'b0, 1'b0});
    tick();                                       // cycle 17
    check("pre_timeout", obs, {3'd6, 3'd0, 1'b0, 6'b0, 1'b0, 1'b1});
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("tmo_clear", obs, 15'd0);

    // ---------------- buck2 status stuck low in slot 2 ----------------
    cfg = {3'd7, 3'd7, 3'd7, 3'd2, 3'd1, 3'd0};
    sta_kill = 6'b000100;
    do_reset();
    ssready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;          // cycle 1
    repeat (24) tick();                           // cycle 25, last cycle of slot 2
    check("slot2_last", obs, {3'd2, 3'd2, 1'b1, 6'b000111, 1'b0, 1'b0});
    tick();
    check("slot2_fault", {seq_state, enpre, en_v, seq_fault}, {3'd6, 1'b0, 6'b0, 1'b1});
    sta_kill = '0;
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("slot2_clear", {seq_state, seq_fault}, {3'd0, 1'b0});
    ssready = 1'b0;

    // ---------------- stop+start in slot 3, then fault while stepping down ----------------
    cfg = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    ssready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;          // cycle 1
    repeat (27) tick();                           // cycle 28, inside slot 3
    check("abort_pre", obs, {3'd2, 3'd3, 1'b1, 6'b001111, 1'b0, 1'b0});
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    check("abort_dn3", obs, {3'd4, 3'd3, 1'b1, 6'b000111, 1'b0, 1'b0});
    tick(); tick();
    flt_in = 1'b1; tick(); flt_in = 1'b0;
    check("dn_fault", {seq_state, enpre, en_v, seq_done, seq_fault}, {3'd6, 1'b0, 6'b0, 1'b0, 1'b1});
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("dn_clear", {seq_state, seq_fault}, {3'd0, 1'b0});
    ssready = 1'b0;

    // ---------------- model-checked sequences ----------------
    run_trial({3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3, -2, 0);   // full up, stop in ON
    run_trial({3'd7, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0}, 3, -1, 1);   // sparse slots
    for (int t = 2; t < 32; t++) begin
      logic [5:0][2:0] rc;
      for (int r = 0; r < 6; r++) rc[r] = 3'($urandom_range(0, 7));
      run_trial(rc, int'($urandom_range(1, 15)), int'($urandom_range(0, 1000)), t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_seq_ctrl.md
REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

Interface
REQ-001 Parameter UDLY, default 1, simulation-only register update delay.
REQ-002 Parameter SLOT_CYC, default 20000, slot length in clock cycles (1 ms at 20 MHz), range 2..65535.
REQ-003 Parameter PRE_TMO, default 100000, maximum cycles to wait for VPRE soft start, range 2..2^20-1.
REQ-004 main_clk20m  in  1  main digital 20 MHz clock; sole clock.
REQ-005 por  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  power-up request pulse; stop  in  1  power-down request pulse; fault_clr  in  1  fault clear pulse.
REQ-007 slot_boost, slot_buck1, slot_buck2, slot_buck3, slot_ldo1, slot_ldo2  in  3 each  slot number 0..6; 7 = never enabled.
REQ-008 ssready  in  1  VPRE soft start done; boost_sta, buck1_sta, buck2_sta, buck3_sta, ldo1_sta, ldo2_sta  in  1 each  regulator on status.
REQ-009 flt_in  in  1  OR of regulator OC/OT/OV faults, already synchronised.
REQ-010 enpre, enboost, enbuck1, enbuck2, enbuck3, enldo1, enldo2  out  1 each  regulator enables.
REQ-011 seq_done  out  1  all slots up and checked; seq_fault  out  1  sequencer in FAULT; seq_state  out  3  encoded state; seq_slot  out  3  current slot.

Function
REQ-012 The block SHALL implement states IDLE=0, PRE_ON=1, SLOT_UP=2, ON=3, SLOT_DN=4, PRE_OFF=5, FAULT=6; seq_state SHALL equal the current state.
REQ-013 IDLE + start=1 SHALL move to PRE_ON next cycle, with enpre=1 in that same cycle and the timer cleared.
REQ-014 PRE_ON: ssready=1 SHALL move to SLOT_UP with slot 0; timer reaching PRE_TMO-1 with ssready=0 SHALL move to FAULT.
REQ-015 On entry to SLOT_UP slot k, every regulator with slot_x==k SHALL assert its enable in the entry cycle; enables SHALL remain set.
REQ-016 Each slot SHALL last exactly SLOT_CYC cycles; in the last cycle every regulator with slot_x<=k SHALL be checked, and any *_sta=0 SHALL move to FAULT.
REQ-017 A passing check at k<6 SHALL advance to slot k+1; at k=6 it SHALL move to ON with seq_done=1.
REQ-018 ON + stop=1 SHALL move to SLOT_DN slot 6; SLOT_UP + stop=1 SHALL abort to SLOT_DN at the current slot; seq_done SHALL clear on leaving ON.
REQ-019 On entry to SLOT_DN slot k, regulators with slot_x==k SHALL deassert; after SLOT_CYC cycles, k>0 SHALL step to k-1 and k=0 SHALL move to PRE_OFF.
REQ-020 PRE_OFF SHALL deassert enpre on entry and return to IDLE after SLOT_CYC cycles.
REQ-021 flt_in=1, or ssready=0 in SLOT_UP/ON, in any state except IDLE/FAULT SHALL move to FAULT; all enables SHALL be 0 in the FAULT entry cycle; seq_fault=1.
REQ-022 FAULT SHALL exit to IDLE only on fault_clr=1 with flt_in=0; fault_clr with flt_in=1 SHALL be ignored.
REQ-023 Priority SHALL be fault > stop > start > timer; start outside IDLE and stop in IDLE/PRE_OFF/FAULT SHALL be ignored.
REQ-024 Slot value 7 regulators SHALL never be enabled or checked; sequence timing SHALL be unaffected.
REQ-025 Slot configuration SHALL be sampled live; changes during a sequence are undefined by design and need not be checked.

Reset
REQ-026 por=1 at a clock edge SHALL force IDLE, slot 0, timer 0, all enables 0, seq_done=0, seq_fault=0, seq_state=0, seq_slot=0, regardless of state, including mid-sequence.

Configuration
REQ-027 Macro REG_SEQ_SLOT_SKIP_EN defined: in SLOT_UP/SLOT_DN, a slot with no regulator assigned SHALL last 1 cycle instead of SLOT_CYC (no check performed).
REQ-028 Macro REG_SEQ_SLOT_SKIP_EN undefined: every slot 0..6 SHALL last SLOT_CYC cycles.

Verification (SLOT_CYC=8, PRE_TMO=16)
REQ-029 start, ssready at cycle 3, all slots 0..5 in order, sta follows enables -> enpre at cycle 1, enboost at 4, seq_done after 7x8 slot cycles, no fault.
REQ-030 ssready held 0 -> FAULT after 16 PRE_ON cycles, enpre=0, seq_fault=1; fault_clr -> IDLE.
REQ-031 buck2_sta held 0 with slot_buck2=2 -> FAULT at last cycle of slot 2, all enables 0 next state.
REQ-032 stop in ON -> enables drop in reverse slot order every 8 cycles, enpre drops last, IDLE 8 cycles later.
REQ-033 stop and start simultaneous in SLOT_UP slot 3 -> SLOT_DN slot 3; flt_in pulse during SLOT_DN -> FAULT.
REQ-034 Both macro builds, slots {0,0,0,6,6,7}: macro defined -> slots 1..5 last 1 cycle each; undefined -> 8 each.
